// File: rtl/card_dealer.sv
// card_dealer: picks draw_cnt distinct cards from the 106-slot deck mask and
// offers them one at a time on a valid/ack handshake.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   draw_req, draw_cnt[3:0], entropy[9:0]  - batch request
//   available_card[105:0]                  - live deck availability mask
//   deal_ack                               - consumer accepts offered card
//   busy, deal_valid, deal_idx[6:0], deal_card[5:0], dealt_cnt[3:0],
//   batch_done, deck_empty                 - registered status / offer
//
// Build option: DEALER_DETERMINISTIC_EN forces every scan to start at slot 0,
// so each card is the lowest-indexed free slot. Port list is unchanged.
module card_dealer (
  input  logic         clk,
  input  logic         rst,
  input  logic         draw_req,
  input  logic [3:0]   draw_cnt,
  input  logic [9:0]   entropy,
  input  logic [105:0] available_card,
  input  logic         deal_ack,
  output logic         busy,
  output logic         deal_valid,
  output logic [6:0]   deal_idx,
  output logic [5:0]   deal_card,
  output logic [3:0]   dealt_cnt,
  output logic         batch_done,
  output logic         deck_empty
);

  localparam int unsigned NUM_SLOTS = 106;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;

  state_t         state_reg;
  logic [15:0]    lfsr_reg;
  logic [15:0]    lfsr_next;
  logic [15:0]    lfsr_seeded;
  logic [105:0]   claimed_reg;
  logic [105:0]   eff_mask;
  logic [6:0]     scan_idx_reg;
  logic [6:0]     scan_cnt_reg;
  logic [6:0]     scan_idx_next;
  logic [6:0]     start_idx;
  logic [3:0]     target_reg;
  logic           scan_hit;

  // Slots still eligible this batch: free in the deck and not yet taken.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_eff
      assign eff_mask[gi] = available_card[gi] & ~claimed_reg[gi];
    end
  endgenerate

  // LFSR value for the next cycle; an accepted request folds in entropy and
  // must never leave the register stuck at zero.
  always_comb begin
    lfsr_seeded = lfsr_reg ^ {6'b0, entropy};
    lfsr_next   = {lfsr_reg[14:0],
                   lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    if (state_reg == IDLE && draw_req) begin
      lfsr_next = (lfsr_seeded == 16'h0) ? LFSR_SEED : lfsr_seeded;
    end
  end

  // The start slot is derived from the LFSR value that will be present in
  // the first SCAN cycle, i.e. lfsr_next at the entering edge.
  always_comb begin
`ifdef DEALER_DETERMINISTIC_EN
    start_idx = 7'd0;
`else
    start_idx = (lfsr_next[6:0] >= 7'd106) ? (lfsr_next[6:0] - 7'd106)
                                           : lfsr_next[6:0];
`endif
  end

  assign scan_hit      = eff_mask[scan_idx_reg];
  assign scan_idx_next = (scan_idx_reg == 7'd105) ? 7'd0 : scan_idx_reg + 7'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      lfsr_reg     <= LFSR_SEED;
      claimed_reg  <= '0;
      scan_idx_reg <= '0;
      scan_cnt_reg <= '0;
      target_reg   <= '0;
      busy         <= 1'b0;
      deal_valid   <= 1'b0;
      deal_idx     <= '0;
      deal_card    <= '0;
      dealt_cnt    <= '0;
      batch_done   <= 1'b0;
      deck_empty   <= 1'b0;
    end else begin
      lfsr_reg   <= lfsr_next;
      batch_done <= 1'b0;
      deck_empty <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (draw_req) begin
            claimed_reg <= '0;
            dealt_cnt   <= '0;
            target_reg  <= draw_cnt;
            busy        <= 1'b1;
            if (draw_cnt == 4'd0) begin
              state_reg  <= DONE;
              batch_done <= 1'b1;
            end else begin
              state_reg    <= SCAN;
              scan_idx_reg <= start_idx;
              scan_cnt_reg <= '0;
            end
          end
        end
        SCAN: begin
          if (scan_hit) begin
            // Latch the slot so the offer is immune to later mask changes.
            state_reg  <= OFFER;
            deal_valid <= 1'b1;
            deal_idx   <= scan_idx_reg;
            deal_card  <= (scan_idx_reg < 7'd53) ? scan_idx_reg[5:0]
                                                 : 6'(scan_idx_reg - 7'd53);
          end else if (scan_cnt_reg == 7'd105) begin
            // Every slot examined once with no candidate.
            state_reg  <= DONE;
            batch_done <= 1'b1;
            deck_empty <= 1'b1;
          end else begin
            scan_idx_reg <= scan_idx_next;
            scan_cnt_reg <= scan_cnt_reg + 7'd1;
          end
        end
        OFFER: begin
          if (deal_ack) begin
            claimed_reg[deal_idx] <= 1'b1;
            dealt_cnt             <= dealt_cnt + 4'd1;
            deal_valid            <= 1'b0;
            if (dealt_cnt + 4'd1 == target_reg) begin
              state_reg  <= DONE;
              batch_done <= 1'b1;
            end else begin
              state_reg    <= SCAN;
              scan_idx_reg <= start_idx;
              scan_cnt_reg <= '0;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: directed latency/boundary cases plus randomized
// batches, all compared every cycle against a transaction-level model that
// predicts each offer from a circular first-free-slot search.
module tb_card_dealer;

  localparam int N = 106;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int M_IDLE = 0, M_SCAN = 1, M_OFFER = 2, M_DONE = 3;
`ifdef DEALER_DETERMINISTIC_EN
  localparam int EXP_IDX0 = 0;
`else
  localparam int EXP_IDX0 = 97;  // 16'hACE1[6:0] = 97
`endif
  localparam int EXP_CARD0 = (EXP_IDX0 < 53) ? EXP_IDX0 : EXP_IDX0 - 53;

  logic         clk = 1'b0;
  logic         rst;
  logic         draw_req;
  logic [3:0]   draw_cnt;
  logic [9:0]   entropy;
  logic [105:0] available_card;
  logic         deal_ack;
  logic         busy, deal_valid, batch_done, deck_empty;
  logic [6:0]   deal_idx;
  logic [5:0]   deal_card;
  logic [3:0]   dealt_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_batches = 0;

  card_dealer dut (
    .clk(clk), .rst(rst), .draw_req(draw_req), .draw_cnt(draw_cnt),
    .entropy(entropy), .available_card(available_card), .deal_ack(deal_ack),
    .busy(busy), .deal_valid(deal_valid), .deal_idx(deal_idx),
    .deal_card(deal_card), .dealt_cnt(dealt_cnt), .batch_done(batch_done),
    .deck_empty(deck_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int start_of(input logic [15:0] v);
    int s;
    s = int'(v[6:0]);
    if (s >= N) s -= N;
`ifdef DEALER_DETERMINISTIC_EN
    s = 0;
`endif
    return s;
  endfunction

  // Distance from s to the first set bit going upward with wrap, or -1.
  function automatic int scan_dist(input logic [105:0] m, input int s);
    for (int d = 0; d < N; d++)
      if (m[(s + d) % N]) return d;
    return -1;
  endfunction

  int           m_mode = M_IDLE, m_wait = 0, m_hit = 0, m_idx = 0;
  int           m_dealt = 0, m_target = 0;
  bit           m_empty = 0, m_live = 0;
  logic [15:0]  m_lfsr = SEED;
  logic [105:0] m_claimed = '0;

  task automatic start_scan(input logic [15:0] l);
    int s, d;
    s = start_of(l);
    d = scan_dist(available_card & ~m_claimed, s);
    m_hit  = (d < 0) ? -1 : (s + d) % N;
    m_wait = (d < 0) ? N : d + 1;
    m_mode = M_SCAN;
  endtask

  always @(posedge clk) begin : model
    logic [15:0] nl;
    if (!rst) begin
      m_live = 1; m_mode = M_IDLE; m_lfsr = SEED; m_claimed = '0;
      m_dealt = 0; m_idx = 0; m_empty = 0; m_target = 0;
    end else if (m_live) begin
      nl = lfsr_step(m_lfsr);
      case (m_mode)
        M_IDLE: if (draw_req) begin
          nl = m_lfsr ^ {6'b0, entropy};
          if (nl == 16'h0) nl = SEED;
          m_claimed = '0; m_dealt = 0; m_target = int'(draw_cnt); m_empty = 0;
          if (draw_cnt == 4'd0) m_mode = M_DONE;
          else start_scan(nl);
        end
        M_SCAN: begin
          m_wait--;
          if (m_wait == 0) begin
            if (m_hit >= 0) begin m_idx = m_hit; m_mode = M_OFFER; end
            else begin m_empty = 1; m_mode = M_DONE; end
          end
        end
        M_OFFER: if (deal_ack) begin
          m_claimed[m_idx] = 1'b1;
          m_dealt++;
          if (m_dealt == m_target) m_mode = M_DONE;
          else start_scan(nl);
        end
        default: begin m_mode = M_IDLE; m_empty = 0; end
      endcase
      m_lfsr = nl;
    end
  end

  // ---------------- compare process ----------------
  logic [105:0] batch_seen = '0;
  logic [105:0] seen_any = '0;

  always @(negedge clk) begin
    if (m_live) begin
      check("busy", busy, int'(m_mode != M_IDLE));
      check("deal_valid", deal_valid, int'(m_mode == M_OFFER));
      check("deal_idx", deal_idx, m_idx);
      check("deal_card", deal_card, (m_idx < 53) ? m_idx : m_idx - 53);
      check("dealt_cnt", dealt_cnt, m_dealt);
      check("batch_done", batch_done, int'(m_mode == M_DONE));
      check("deck_empty", deck_empty, int'(m_mode == M_DONE && m_empty));
      if (!rst) batch_seen = '0;
      if (deal_valid && deal_ack && rst) begin
        check("idx_range", int'(deal_idx < 7'd106), 1);
        if (deal_idx < 7'd106) begin
          check("dup_idx", int'(batch_seen[deal_idx]), 0);
          batch_seen[deal_idx] = 1'b1;
          seen_any[deal_idx]   = 1'b1;
        end
      end
      if (batch_done) begin
        n_batches++;
        $display("batch %0d done: dealt=%0d deck_empty=%0d",
                 n_batches, dealt_cnt, deck_empty);
        batch_seen = '0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_draw(input int cnt, input logic [9:0] ent);
    draw_cnt = 4'(cnt);
    entropy  = ent;
    draw_req = 1'b1;
    tick();
    draw_req = 1'b0;
  endtask

  // Called right after start_draw; n counts cycles since the request cycle.
  task automatic wait_valid(input int max, output int n);
    n = 1;
    while (!deal_valid && n < max) begin
      tick();
      n++;
    end
    if (!deal_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic finish_batch(input int pct);
    int k;
    k = 0;
    while (busy && k < 4000) begin
      deal_ack = ($urandom_range(0, 99) < pct);
      tick();
      k++;
    end
    deal_ack = 1'b0;
    if (busy) check("batch_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n, cap;
    bit saw_valid;
    rst = 1'b0; draw_req = 1'b0; draw_cnt = '0; entropy = '0;
    available_card = '1; deal_ack = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", deal_valid, 0);
    check("rst_dealt", dealt_cnt, 0);
    check("rst_done", batch_done, 0);

    // Request in the first cycle after reset: best-case latency, known slot.
    rst = 1'b1;
    start_draw(2, 10'h000);
    wait_valid(200, n);
    check("lat_best", n, 2);
    check("first_idx", deal_idx, EXP_IDX0);
    check("first_card", deal_card, EXP_CARD0);
    check("model_idx0", m_idx, EXP_IDX0);
    finish_batch(100);
    check("a_dealt", dealt_cnt, 2);

    // Only slot 105 free, scan starts at 0: worst-case latency and wrap.
    rst = 1'b0; tick(); rst = 1'b1;
    available_card = '0;
    available_card[105] = 1'b1;
    start_draw(1, 10'h0E1);  // 16'hACE1 ^ 10'h0E1 -> low bits 0
    wait_valid(200, n);
    check("lat_worst", n, 107);
    check("wrap_idx", deal_idx, 105);
    check("wrap_card", deal_card, 52);
    deal_ack = 1'b1; tick(); deal_ack = 1'b0;
    check("wrap_done", batch_done, 1);
    check("wrap_no_empty", deck_empty, 0);
    check("wrap_dealt", dealt_cnt, 1);
    tick();
    check("wrap_idle", busy, 0);

    // Zero-card batch.
    start_draw(0, 10'($urandom));
    check("zero_done", batch_done, 1);
    check("zero_no_empty", deck_empty, 0);
    tick();
    check("zero_idle", busy, 0);

    // Empty deck.
    available_card = '0;
    start_draw(3, 10'($urandom));
    n = 1; saw_valid = 0;
    while (!batch_done && n < 300) begin
      if (deal_valid) saw_valid = 1;
      tick();
      n++;
    end
    check("empty_lat", n, 107);
    check("empty_flag", deck_empty, 1);
    check("empty_no_valid", int'(saw_valid), 0);
    tick();
    check("empty_idle", busy, 0);

    // Backpressure: offered slot toggles in the mask, stray draw_req.
    available_card = '1;
    start_draw(2, 10'($urandom));
    wait_valid(300, n);
    cap = int'(deal_idx);
    for (int i = 0; i < 20; i++) begin
      available_card[cap] = ~available_card[cap];
      if (i == 7) begin draw_req = 1'b1; draw_cnt = 4'd9; end
      tick();
      draw_req = 1'b0;
    end
    finish_batch(100);
    check("bp_dealt", dealt_cnt, 2);

    // Reset while an offer is pending, then restart as from power-up.
    start_draw(5, 10'($urandom));
    wait_valid(300, n);
    rst = 1'b0; tick(); rst = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", deal_valid, 0);
    check("mid_rst_dealt", dealt_cnt, 0);
    start_draw(1, 10'h000);
    wait_valid(200, n);
    check("rst_lat", n, 2);
    check("rst_idx", deal_idx, EXP_IDX0);
    finish_batch(100);

    // Randomized batches: sparse masks first, then full 14-card deals.
    for (int b = 0; b < 1060; b++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (b < 60) begin
        for (int i = 0; i < N; i++) available_card[i] = ($urandom_range(0, 7) == 0);
        start_draw($urandom_range(0, 14), 10'($urandom));
      end else begin
        available_card = '1;
        start_draw(14, 10'($urandom));
      end
      finish_batch(80);
    end

`ifndef DEALER_DETERMINISTIC_EN
    for (int i = 0; i < N; i++) check($sformatf("cover_%0d", i), int'(seen_any[i]), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Random card dealer for the game controller. On a draw request it picks `draw_cnt` distinct cards from the 106-slot deck-availability mask and offers them one at a time on a valid/ack handshake. The game-control FSM consumes each offered card to build its DECK_DRAW messages and memory updates. It serves both the 14-card initial deal and the single-card draw-and-next.

## Interface
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `draw_req` in 1: one-cycle pulse that starts a batch; ignored while `busy`.
- `draw_cnt` in 4: number of cards in the batch, 0..14; sampled on `draw_req`.
- `entropy` in 10: free-running noise (e.g. mouse_x); XORed into the LFSR on `draw_req`.
- `available_card` in 106: bit i=1 means deck slot i is undrawable-free; read live every cycle.
- `deal_ack` in 1: consumer accepts the offered card.
- `busy` out 1: a batch is in progress.
- `deal_valid` out 1: a card is offered.
- `deal_idx` out 7: deck slot 0..105.
- `deal_card` out 6: card code; `deal_idx` if <53, else `deal_idx`−53.
- `dealt_cnt` out 4: cards accepted in the current batch.
- `batch_done` out 1: one-cycle pulse at the end of a batch.
- `deck_empty` out 1: one-cycle pulse, asserted together with `batch_done` when the batch is cut short.

## Operation
- **LFSR**
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle.
  - Reset value 16'hACE1.
  - On `draw_req` it loads `lfsr ^ {6'b0, entropy}`; a zero result loads 16'hACE1 instead.
- **Start index:** `s = lfsr[6:0]`; if `s` ≥ 106, use `s`−106. This is taken from the LFSR value in the cycle the state is entered.
- **Claimed mask** (106 bits): cleared on `draw_req`; bit set on each accepted card. The effective mask is `available_card & ~claimed`, so a card is never offered twice before memory clears it.
- **FSM**
  - IDLE: on `draw_req` with `draw_cnt`=0 → DONE. On `draw_req` with `draw_cnt`>0 → SCAN. Otherwise stay.
  - SCAN: examine one index per cycle starting at `s`, wrapping 105→0. Keep a scan counter of 0..106.
    - Effective bit = 1: latch `idx` → OFFER.
    - 106 indices examined with no hit → DONE with `deck_empty` set.
  - OFFER: `deal_valid`=1. `deal_idx` and `deal_card` are held stable until `deal_ack`, even if `available_card` changes.
    - On ack: set the claimed bit and increment `dealt_cnt`.
    - If `dealt_cnt`+1 = `draw_cnt` → DONE; else → SCAN with a fresh `s`.
  - DONE: `batch_done` pulses (plus `deck_empty` if flagged) → IDLE.
- `busy` = state ≠ IDLE, and includes the DONE cycle.
- `deal_ack` outside OFFER is ignored. `draw_req` outside IDLE is ignored.
- `dealt_cnt` holds its value after the batch until the next `draw_req` clears it.

## Timing
- **Reset:** `rst` low at an edge → next cycle is IDLE with all outputs 0, claimed mask cleared, LFSR = 16'hACE1. Applies mid-batch, with no further pulses.
- **Latency:** `draw_req` at cycle T → SCAN examines `s` at T+1. A hit at cycle c → `deal_valid` at c+1.
  - Best case: `draw_req` to `deal_valid` is 2 cycles.
  - Worst case: 107 cycles.
- **Handshake:** transfer when `deal_valid & deal_ack` at an edge. `deal_valid` drops the next cycle, because the state returns to SCAN or DONE.
- **Batch end:** `batch_done` asserts the cycle after the final ack. With `draw_cnt`=0 it asserts at T+1.
- **Empty deck:** with no effective bits, `batch_done`/`deck_empty` assert at T+107.

## Configuration
- **`DEALER_DETERMINISTIC_EN` defined:**
  - `s` is forced to 0 every time; the LFSR and `entropy` are unused.
  - Each card is the lowest-indexed available, unclaimed slot.
  - Intended for bench and board bring-up.
- **Undefined:** LFSR-based random start as described above.
- The port list is identical in both builds.

## Test plan
- **Full deck, deterministic:** `draw_cnt`=14, ack every cycle → 14 offers with idx 0..13 and cards 0..13; `dealt_cnt`=14; `batch_done` the cycle after the 14th ack; `deck_empty`=0.
- **Wrap and second copy, deterministic:** `available_card` has only bits 0 and 105 set, `draw_cnt`=2 → idx 0 (card 0), then idx 105 (card 52); `batch_done` with no `deck_empty`.
- **Empty deck:** `available_card`=0, `draw_cnt`=3 → no `deal_valid`; `batch_done` and `deck_empty` both at T+107; `busy` falls at T+108.
- **Backpressure:** hold `deal_ack`=0 for 20 cycles while toggling `available_card[deal_idx]` → `deal_valid`, `deal_idx` and `deal_card` stay constant for all 20 cycles; the first ack is accepted.
- **Reset mid-OFFER:** drive `rst`=0 for one cycle → next cycle `busy`=0, `deal_valid`=0, `dealt_cnt`=0. A later `draw_req` behaves as from power-up (LFSR back to 16'hACE1).
- **Random build:** 1000 batches of `draw_cnt`=14 on a full deck with varying `entropy` → no duplicate idx within any batch; every idx <106; every slot 0..105 is hit at least once.
